// File: rtl/csoc_scan_emu.sv
// csoc_scan_emu: multi-chain scan emulator with a capture cycle, a per-load
// shift counter with a load-done pulse, and a MISR compacting the scan-out bits.
module csoc_scan_emu #(
   parameter int unsigned        NCHAINS   = 8,
   parameter int unsigned        CHAIN_LEN = 240,
   parameter logic [NCHAINS-1:0] MISR_POLY = 8'h1D
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         test_tm_i,
   input  logic                         test_se_i,
   input  logic                         capture_i,
   input  logic [NCHAINS-1:0]           scan_i,
   output logic [NCHAINS-1:0]           scan_o,
   input  logic                         misr_clr_i,
   output logic [NCHAINS-1:0]           misr_o,
   output logic [$clog2(CHAIN_LEN)-1:0] shift_cnt_o,
   output logic                         load_done_o
);

   localparam int unsigned   CW       = $clog2(CHAIN_LEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LEN - 1);

   typedef enum logic [1:0] {
      MODE_IDLE    = 2'd0,
      MODE_SHIFT   = 2'd1,
      MODE_CAPTURE = 2'd2,
      MODE_HOLD    = 2'd3
   } mode_t;

   // One MISR step: shift left, fold the MSB back through the taps, absorb data.
   function automatic logic [NCHAINS-1:0] misr_step(input logic [NCHAINS-1:0] cur,
                                                    input logic [NCHAINS-1:0] din);
      logic [NCHAINS-1:0] fb;
      fb = cur[NCHAINS-1] ? MISR_POLY : {NCHAINS{1'b0}};
      return ({cur[NCHAINS-2:0], 1'b0} ^ fb) ^ din;
   endfunction

   mode_t              mode_s;
   logic [CHAIN_LEN-1:0] chain_r     [NCHAINS];
   logic [CHAIN_LEN-1:0] chain_nxt_s [NCHAINS];
   logic [NCHAINS-1:0] scan_s;
   logic [NCHAINS-1:0] misr_r;
   logic [NCHAINS-1:0] misr_nxt_s;
   logic [CW-1:0]      cnt_r;
   logic [CW-1:0]      cnt_nxt_s;
   logic               done_r;
   logic               done_nxt_s;

   // Mode decode: test mode off wins, then shift, then capture, else hold.
   always_comb begin
      mode_s = MODE_HOLD;
      if (!test_tm_i) begin
         mode_s = MODE_IDLE;
      end else if (test_se_i) begin
         mode_s = MODE_SHIFT;
      end else if (capture_i) begin
         mode_s = MODE_CAPTURE;
      end else begin
         mode_s = MODE_HOLD;
      end
   end

   // Scan-out vector: bit 0 of every chain, straight from the flops.
   always_comb begin
      scan_s = {NCHAINS{1'b0}};
      for (int k = 0; k < NCHAINS; k++) begin
         scan_s[k] = chain_r[k][0];
      end
   end

   // Next chain contents: shift in from the MSB end, or invert on capture.
   always_comb begin
      chain_nxt_s = chain_r;
      for (int k = 0; k < NCHAINS; k++) begin
         case (mode_s)
            MODE_SHIFT:   chain_nxt_s[k] = {scan_i[k], chain_r[k][CHAIN_LEN-1:1]};
            MODE_CAPTURE: chain_nxt_s[k] = ~chain_r[k];
            default:      chain_nxt_s[k] = chain_r[k];
         endcase
      end
   end

   // Next counter, load-done and MISR; clear beats a shift update on the MISR.
   always_comb begin
      cnt_nxt_s  = cnt_r;
      done_nxt_s = 1'b0;
      misr_nxt_s = misr_r;
      case (mode_s)
         MODE_IDLE: begin
            cnt_nxt_s = {CW{1'b0}};
         end
         MODE_SHIFT: begin
            misr_nxt_s = misr_step(misr_r, scan_s);
            if (cnt_r == CNT_LAST) begin
               cnt_nxt_s  = {CW{1'b0}};
               done_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r + CW'(1'b1);
            end
         end
         MODE_CAPTURE: begin
            cnt_nxt_s = {CW{1'b0}};
         end
         default: begin
            cnt_nxt_s = cnt_r;
         end
      endcase
      if (misr_clr_i) begin
         misr_nxt_s = {NCHAINS{1'b0}};
      end else begin
         misr_nxt_s = misr_nxt_s;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < NCHAINS; k++) begin
            chain_r[k] <= {CHAIN_LEN{1'b0}};
         end
         misr_r <= {NCHAINS{1'b0}};
         cnt_r  <= {CW{1'b0}};
         done_r <= 1'b0;
      end else begin
         chain_r <= chain_nxt_s;
         misr_r  <= misr_nxt_s;
         cnt_r   <= cnt_nxt_s;
         done_r  <= done_nxt_s;
      end
   end

   assign scan_o      = scan_s;
   assign misr_o      = misr_r;
   assign shift_cnt_o = cnt_r;
   assign load_done_o = done_r;

endmodule

// File: tb/tb_csoc_scan_emu.sv
// Scoreboard bench for csoc_scan_emu: chains modelled as bit-vector FIFOs.
module tb_csoc_scan_emu;

   localparam int N = 4;
   localparam int L = 8;
   localparam logic [N-1:0] POLY = 4'h3;

   logic         clk;
   logic         rst;
   logic         tm, se, cap, clr;
   logic [N-1:0] sin;
   logic [N-1:0] scan_o, misr_o;
   logic [2:0]   cnt_o;
   logic         done_o;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [N-1:0] scan;
      logic [N-1:0] misr;
      logic [2:0]   cnt;
      logic         done;
   } exp_t;

   exp_t       sb[$];
   logic [N-1:0] mq[$];   // mq[0] is the next bit vector to leave the chains
   logic [N-1:0] m_misr;
   int           m_cnt;

   csoc_scan_emu #(.NCHAINS(N), .CHAIN_LEN(L), .MISR_POLY(POLY)) dut (
      .clk_i(clk), .rst_i(rst), .test_tm_i(tm), .test_se_i(se),
      .capture_i(cap), .scan_i(sin), .scan_o(scan_o), .misr_clr_i(clr),
      .misr_o(misr_o), .shift_cnt_o(cnt_o), .load_done_o(done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] misr_ref(input logic [N-1:0] m, input logic [N-1:0] d);
      logic [N-1:0] r;
      r = (m << 1) ^ d;
      if (m[N-1]) r = r ^ POLY;
      return r;
   endfunction

   task automatic model_reset();
      mq.delete();
      for (int i = 0; i < L; i++) mq.push_back(4'h0);
      m_misr = 4'h0;
      m_cnt  = 0;
   endtask

   // One clocked cycle of stimulus; the model's post-edge view is queued.
   task automatic drive(input logic t, input logic s, input logic c,
                        input logic [N-1:0] d, input logic cl);
      exp_t e;
      logic [N-1:0] out;
      logic dn;
      @(negedge clk);
      #1;
      tm = t; se = s; cap = c; sin = d; clr = cl;
      out = mq[0];
      dn  = 1'b0;
      if (!t) begin
         m_cnt = 0;
      end else if (s) begin
         void'(mq.pop_front());
         mq.push_back(d);
         m_misr = misr_ref(m_misr, out);
         if (m_cnt == L - 1) begin
            m_cnt = 0;
            dn = 1'b1;
         end else begin
            m_cnt = m_cnt + 1;
         end
      end else if (c) begin
         for (int i = 0; i < L; i++) mq[i] = ~mq[i];
         m_cnt = 0;
      end
      if (cl) m_misr = 4'h0;
      e.scan = mq[0];
      e.misr = m_misr;
      e.cnt  = 3'(m_cnt);
      e.done = dn;
      sb.push_back(e);
   endtask

   // Asynchronous reset pulse between edges, checked before the next edge.
   task automatic do_reset();
      @(negedge clk);
      #1;
      tm = 1'b0; se = 1'b0; cap = 1'b0; clr = 1'b0; sin = 4'h0;
      rst = 1'b1;
      #2;
      chk("rst_scan_o", 32'(scan_o), 32'h0);
      chk("rst_misr_o", 32'(misr_o), 32'h0);
      chk("rst_cnt_o",  32'(cnt_o),  32'h0);
      chk("rst_done_o", 32'(done_o), 32'h0);
      model_reset();
      @(negedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: compare every clocked response against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("scan_o",      32'(scan_o), 32'(e.scan));
         chk("misr_o",      32'(misr_o), 32'(e.misr));
         chk("shift_cnt_o", 32'(cnt_o),  32'(e.cnt));
         chk("load_done_o", 32'(done_o), 32'(e.done));
      end
   end

   initial begin
      rst = 1'b1; tm = 1'b0; se = 1'b0; cap = 1'b0; clr = 1'b0; sin = 4'h0;
      model_reset();
      #12;
      do_reset();

      // Full load of 1010 on every shift.
      for (int i = 0; i < L; i++) drive(1'b1, 1'b1, 1'b0, 4'b1010, 1'b0);
      // Load zeros, then two captures.
      for (int i = 0; i < L; i++) drive(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 4'h0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 4'h0, 1'b0);
      // Shift beats capture; clear during shift.
      drive(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 4'b1001, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 4'b1111, 1'b1);
      // MISR with zero chains, then with chains preloaded to all ones.
      for (int i = 0; i < L; i++) drive(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
      for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
      for (int i = 0; i < L; i++) drive(1'b1, 1'b1, 1'b0, 4'hF, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
      for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
      // Pause with se low, then drop tm mid-load.
      drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 4'h5, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 4'hA, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 4'h3, 1'b0);
      for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 1'b0, 4'hC, 1'b0);
      for (int i = 0; i < L; i++) drive(1'b1, 1'b1, 1'b0, 4'h9, 1'b0);
      // Reset in the middle of a load.
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 4'h7, 1'b0);
      do_reset();

      // Randomised traffic.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
         end else begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), 4'($urandom),
                  $urandom_range(0, 11) == 0);
         end
      end

      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/csoc_scan_emu.md
Name: csoc_scan_emu

Overview:
- Parametrised scan-chain emulator for CSOC pad-level test bring-up.
- Models NCHAINS parallel scan chains of CHAIN_LEN flops, each with its own scan-in and scan-out.
- Adds a capture cycle, a per-load shift counter with a load-done pulse, and a MISR signature compactor on the scan outputs.
- Sits behind the CSOC data pads, so testers can exercise full multi-chain scan protocols without silicon.

Parameters:
- NCHAINS, 8, number of parallel chains (≥2).
- CHAIN_LEN, 240, flops per chain (≥2).
- MISR_POLY, 8'h1D, feedback polynomial taps. Width NCHAINS; bit i set means XOR the MSB into bit i.

Ports:
- clk_i, input, 1: sole clock; all flops on its rising edge.
- rst_i, input, 1: asynchronous, active-high reset.
- test_tm_i, input, 1: test mode; block inactive when low.
- test_se_i, input, 1: scan enable; shift when high in test mode.
- capture_i, input, 1: capture strobe; sampled in test mode with test_se_i low.
- scan_i, input, NCHAINS: serial scan-in, bit k feeds chain k.
- scan_o, output, NCHAINS: serial scan-out, bit k = chain k bit 0.
- misr_clr_i, input, 1: synchronous MISR clear.
- misr_o, output, NCHAINS: current MISR signature.
- shift_cnt_o, output, $clog2(CHAIN_LEN): shifts completed in the current load.
- load_done_o, output, 1: one-cycle pulse marking completion of a full CHAIN_LEN-shift load.

Behaviour:
- Reset (async, rst_i=1):
  - All chain flops, MISR, shift counter and load_done_o go to 0 immediately.
  - scan_o, misr_o and shift_cnt_o therefore read 0.
  - Reset mid-shift discards partial load; counting restarts at 0 after release.
- Mode decode, evaluated per cycle, priority top-down:
  - test_tm_i=0: IDLE. Chains and MISR hold; shift counter forced to 0; load_done_o=0.
  - test_tm_i=1, test_se_i=1: SHIFT. capture_i is ignored, so shift wins over capture.
  - test_tm_i=1, test_se_i=0, capture_i=1: CAPTURE.
  - Otherwise: HOLD. Everything holds and load_done_o=0.
- SHIFT, per chain k:
  - chain_k becomes {scan_i[k], chain_k[CHAIN_LEN-1:1]}.
  - scan_o[k] = chain_k[0], taken directly from a flop, so there is no combinational path from scan_i.
  - A bit presented at shift n appears on scan_o after exactly CHAIN_LEN shift edges.
  - Shift counter increments and wraps from CHAIN_LEN-1 to 0.
  - load_done_o is asserted in the cycle after the shift edge on which the counter wraps, i.e. registered and high for exactly one cycle.
- CAPTURE:
  - Functional response model: every chain loads its own bitwise inverse (chain_k becomes ~chain_k) in one cycle.
  - Counter resets to 0. MISR unchanged. A held capture_i re-inverts every cycle.
- MISR:
  - Updates only on SHIFT cycles, using the pre-edge scan_o vector (the bits being shifted out).
  - misr_nxt = ({misr[NCHAINS-2:0],1'b0} XOR (misr[NCHAINS-1] ? MISR_POLY : 0)) XOR scan_o.
  - misr_clr_i=1 forces the MISR to 0 on the next edge in any mode and overrides a simultaneous SHIFT update.
  - Chains still shift in that cycle.
- Dropping test_se_i or test_tm_i mid-load:
  - Dropping test_se_i (HOLD) pauses the counter, which resumes on the next SHIFT.
  - Dropping test_tm_i zeros the counter; chain contents are kept.
- Widths:
  - Counter width is $clog2(CHAIN_LEN) with explicit wrap compare. Non-power-of-two CHAIN_LEN is legal and must wrap at CHAIN_LEN-1.

Test Plan (NCHAINS=4, CHAIN_LEN=8, MISR_POLY=4'h3 unless noted):
1. Reset: pulse rst_i asynchronously between clock edges -> scan_o, misr_o, shift_cnt_o, load_done_o = 0 before the next clk_i edge.
2. Full load: tm=1, se=1, scan_i=4'b1010 for 8 cycles -> shift_cnt_o runs 1..7 then 0; load_done_o high for exactly one cycle after the 8th edge; scan_o=4'b1010.
3. Capture: after loading all zeros, se=0, capture_i=1 for one cycle -> next cycle scan_o=4'b1111; shift_cnt_o=0; misr_o unchanged. A second capture returns scan_o to 4'b0000.
4. Priority/clear:
   - se=1 and capture_i=1 together -> chains shift, no inversion.
   - misr_clr_i=1 during shift -> misr_o=0 next cycle while scan_o still advances.
5. MISR signature:
   - Clear, then shift 16 cycles with all chains zero and scan_i=0 -> misr_o stays 4'h0.
   - Repeat with chains preloaded 8'hFF -> misr_o matches a bit-accurate reference model every cycle.
6. Mode interruption: drop se for 3 cycles after 5 shifts -> counter holds at 5 and finishes after 3 more shifts. Drop tm mid-load -> counter=0, chains retained, no load_done_o.
